// File: rtl/alu_pkg.sv
// Shared ALU control codes, multiply/divide op encodings and sequencer states.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Bit 0 selects divide, bit 1 selects signed (signed forms exist only with SIGNED_MD_EN).
  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_DIVU  = 2'b01;
  localparam logic [1:0] MD_MULT  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } md_state_t;

endpackage

// File: rtl/md_sign_fix.sv
// Operand magnitude at accept and sign restoration of HI/LO after the unsigned iteration.
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             signed_op,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] mag_a,
  output logic [WIDTH-1:0] mag_b,
  output logic             neg_q,
  output logic             neg_r,
  input  logic             fix_is_div,
  input  logic             fix_neg_q,
  input  logic             fix_neg_r,
  input  logic [WIDTH-1:0] res_hi,
  input  logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] fix_hi,
  output logic [WIDTH-1:0] fix_lo
);

  logic             a_neg;
  logic             b_neg;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  assign a_neg = signed_op & opa[WIDTH-1];
  assign b_neg = signed_op & opb[WIDTH-1];
  assign mag_a = a_neg ? -opa : opa;
  assign mag_b = b_neg ? -opb : opb;
  assign neg_q = a_neg ^ b_neg;
  // Remainder follows the dividend's sign only.
  assign neg_r = a_neg & is_div;

  assign prod     = {res_hi, res_lo};
  assign prod_neg = -prod;

  always_comb begin
    fix_hi = res_hi;
    fix_lo = res_lo;
    if (fix_is_div) begin
      if (fix_neg_q) fix_lo = -res_lo;
      if (fix_neg_r) fix_hi = -res_hi;
    end else if (fix_neg_q) begin
      {fix_hi, fix_lo} = prod_neg;
    end
  end

endmodule

// File: rtl/alu_md_sequencer.sv
// Multi-cycle shift-add multiply / restoring divide driving the shared ALU, results in HI/LO.
// Define SIGNED_MD_EN to add signed MULT/DIV (2-bit op, extra FIX state).
module alu_md_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SIGNED_MD_EN
  input  logic [1:0]       op,
`else
  input  logic             op,
`endif
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_srcA,
  output logic [WIDTH-1:0] alu_srcB,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry
);

  md_state_t        state_reg, state_next;
  md_state_t        iter_exit;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] m_reg, m_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic             dz_reg, dz_next;
  logic             is_div_op;
  logic [WIDTH-1:0] load_m;
  logic [WIDTH-1:0] load_lo;
  logic [WIDTH-1:0] div_r;
  logic             div_ok;

`ifdef SIGNED_MD_EN
  logic             neg_q_reg, neg_q_next;
  logic             neg_r_reg, neg_r_next;
  logic             fdiv_reg, fdiv_next;
  logic [WIDTH-1:0] mag_a, mag_b, fix_hi, fix_lo;
  logic             neg_q, neg_r;

  assign is_div_op = op[0];

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .signed_op  (op[1]),
    .is_div     (op[0]),
    .opa        (opa),
    .opb        (opb),
    .mag_a      (mag_a),
    .mag_b      (mag_b),
    .neg_q      (neg_q),
    .neg_r      (neg_r),
    .fix_is_div (fdiv_reg),
    .fix_neg_q  (neg_q_reg),
    .fix_neg_r  (neg_r_reg),
    .res_hi     (hi_reg),
    .res_lo     (lo_reg),
    .fix_hi     (fix_hi),
    .fix_lo     (fix_lo)
  );

  assign load_m    = is_div_op ? mag_b : mag_a;
  assign load_lo   = is_div_op ? mag_a : mag_b;
  assign iter_exit = S_FIX;
`else
  assign is_div_op = op;
  assign load_m    = op ? opb : opa;
  assign load_lo   = op ? opa : opb;
  assign iter_exit = S_DONE;
`endif

  // Restoring step: partial remainder shifted left by one; a set msb means r already exceeds M.
  assign div_r  = {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]};
  assign div_ok = hi_reg[WIDTH-1] | ~alu_carry;

  assign hi = hi_reg;
  assign lo = lo_reg;
  assign dz = dz_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      m_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      dz_reg    <= 1'b0;
`ifdef SIGNED_MD_EN
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      fdiv_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      m_reg     <= m_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      dz_reg    <= dz_next;
`ifdef SIGNED_MD_EN
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      fdiv_reg  <= fdiv_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    m_next     = m_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    dz_next    = dz_reg;
`ifdef SIGNED_MD_EN
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    fdiv_next  = fdiv_reg;
`endif
    busy     = (state_reg != S_IDLE);
    done     = (state_reg == S_DONE);
    alu_own  = 1'b0;
    alu_srcA = '0;
    alu_srcB = '0;
    alu_ctrl = ALU_ADD;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          m_next     = load_m;
          lo_next    = load_lo;
          hi_next    = '0;
          count_next = CNT_W'(WIDTH);
          dz_next    = is_div_op && (opb == '0);
          state_next = is_div_op ? S_DIV : S_MUL;
`ifdef SIGNED_MD_EN
          neg_q_next = neg_q;
          neg_r_next = neg_r;
          fdiv_next  = is_div_op;
`endif
        end
      end

      S_MUL: begin
        alu_own    = 1'b1;
        alu_srcA   = hi_reg;
        alu_srcB   = lo_reg[0] ? m_reg : '0;
        alu_ctrl   = ALU_ADD;
        hi_next    = {alu_carry, alu_result[WIDTH-1:1]};
        lo_next    = {alu_result[0], lo_reg[WIDTH-1:1]};
        count_next = count_reg - CNT_W'(1);
        if (count_reg == CNT_W'(1)) state_next = iter_exit;
      end

      S_DIV: begin
        alu_own    = 1'b1;
        alu_srcA   = div_r;
        alu_srcB   = m_reg;
        alu_ctrl   = ALU_SUB;
        hi_next    = div_ok ? alu_result : div_r;
        lo_next    = {lo_reg[WIDTH-2:0], div_ok};
        count_next = count_reg - CNT_W'(1);
        if (count_reg == CNT_W'(1)) state_next = iter_exit;
      end

`ifdef SIGNED_MD_EN
      S_FIX: begin
        hi_next    = fix_hi;
        lo_next    = fix_lo;
        state_next = S_DONE;
      end
`endif

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule
